// File: rtl/ppu_bg_pixel_fifo.sv
// Background pixel FIFO for PPU mode 3: takes 8-pixel tile rows from the fetcher,
// drops the SCX fine-scroll pixels, then emits one visible pixel per enabled dot.
module ppu_bg_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int PIX_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         line_start,
    input  logic [2:0]                   scx_fine,
    input  logic                         dot_en,
    input  logic                         wr_en,
    input  logic [8*PIX_W-1:0]           wr_data,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         out_valid,
    output logic [PIX_W-1:0]             out_color,
    output logic [7:0]                   out_x,
    output logic                         line_done
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - 8);
    localparam logic [7:0] LAST_X = 8'd159;

    typedef enum logic [1:0] {IDLE, DISCARD, OUTPUT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [PIX_W-1:0] mem      [DEPTH];
    logic [PIX_W-1:0] mem_next [DEPTH];
    logic [2:0]       discard_cnt;
    logic [7:0]       x_cnt;
    logic             push;
    logic             push_reject;
    logic             pop;
    logic [CW-1:0]    base;

    assign empty = (count == '0);

    // line_start wins over everything; push room is judged on count before any pop.
    always_comb begin
        push        = wr_en && !line_start && (count <= PUSH_LIMIT);
        push_reject = wr_en && !line_start && (count > PUSH_LIMIT);
        pop         = dot_en && !line_start && (count != '0) &&
                      ((state == DISCARD) || (state == OUTPUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (line_start) begin
            state_next = (scx_fine != 3'd0) ? DISCARD : OUTPUT;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                DISCARD: if (pop && discard_cnt == 3'd1) state_next = OUTPUT;
                OUTPUT:  if (pop && x_cnt == LAST_X) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Index 0 is the head. A pop shifts left first, so new pixels land behind the
    // remaining old ones and the popped pixel is always pre-existing data.
    always_comb begin
        base = pop ? (count - CW'(1)) : count;
        for (int i = 0; i < DEPTH; i++) mem_next[i] = mem[i];
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_next[i] = mem[i+1];
            mem_next[DEPTH-1] = '0;
        end
        if (push) begin
            for (int k = 0; k < 8; k++)
                mem_next[AW'(base + CW'(k))] = wr_data[(8-k)*PIX_W-1 -: PIX_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
            out_color   <= '0;
            out_x       <= 8'd0;
            line_done   <= 1'b0;
            discard_cnt <= 3'd0;
            x_cnt       <= 8'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_next[i];
            out_valid <= 1'b0;
            line_done <= 1'b0;
            if (line_start) begin
                count       <= '0;
                x_cnt       <= 8'd0;
                out_x       <= 8'd0;
                discard_cnt <= scx_fine;
                overflow    <= 1'b0;
            end else begin
                count <= count + (push ? CW'(8) : CW'(0)) - (pop ? CW'(1) : CW'(0));
                if (push_reject) overflow <= 1'b1;
                if (pop) begin
                    if (state == DISCARD) begin
                        discard_cnt <= discard_cnt - 3'd1;
                    end else begin
                        out_color <= mem[0];
                        out_x     <= x_cnt;
                        out_valid <= 1'b1;
                        x_cnt     <= x_cnt + 8'd1;
                        if (x_cnt == LAST_X) line_done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
